// File: rtl/fifo_pkg.sv
// Shared FIFO constants and sizing helpers.
// Pointer width is one bit wider than the address to tell full from empty.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for sync_fifo_param.
// Synchronous write, synchronous registered read, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with sticky overflow/underflow flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_W-1:0]       DIN,
  input  logic                    WR_EN,
  input  logic                    RD_EN,
  input  logic                    CLR_ERR,
  output logic [DATA_W-1:0]       DOUT,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic                    ALMOST_FULL,
  output logic                    ALMOST_EMPTY,
  output logic [ptr_w(DEPTH)-1:0] COUNT,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LVL   = PW'(DEPTH - AF_MARGIN);
  localparam logic [PW-1:0] AE_LVL   = PW'(AE_MARGIN);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     cnt;
  logic              wr_acc;
  logic              rd_acc;
  logic              ram_re;
  logic              mem_empty;
  logic              dout_zero;
  logic [DATA_W-1:0] ram_q;

  assign mem_empty = (wr_ptr == rd_ptr);

`ifdef SYNC_FIFO_FWFT_EN
  // RAM read register doubles as the one-entry output stage.
  logic ovalid;

  assign FULL   = (cnt == FULL_CNT);
  assign EMPTY  = ~ovalid;
  assign rd_acc = RD_EN & ovalid;
  assign ram_re = ~mem_empty & (~ovalid | rd_acc);

  always_ff @(posedge CLK) begin
    if (RST) ovalid <= 1'b0;
    else     ovalid <= ram_re | (ovalid & ~rd_acc);
  end
`else
  assign FULL   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                & (wr_ptr[AW] != rd_ptr[AW]);
  assign EMPTY  = mem_empty;
  assign rd_acc = RD_EN & ~mem_empty;
  assign ram_re = rd_acc;
`endif

  assign wr_acc = WR_EN & ~FULL;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .CLK   (CLK),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (DIN),
    .re    (ram_re),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      dout_zero <= 1'b1;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (ram_re) begin
        rd_ptr    <= rd_ptr + ONE;
        dout_zero <= 1'b0;
      end
      if (wr_acc & ~rd_acc)      cnt <= cnt + ONE;
      else if (rd_acc & ~wr_acc) cnt <= cnt - ONE;
      // A new error event wins over a clear in the same cycle.
      if (WR_EN & FULL)  OVERFLOW <= 1'b1;
      else if (CLR_ERR)  OVERFLOW <= 1'b0;
      if (RD_EN & EMPTY) UNDERFLOW <= 1'b1;
      else if (CLR_ERR)  UNDERFLOW <= 1'b0;
    end
  end

  // RAM output is not reset, so mask it until the first read.
  assign DOUT         = dout_zero ? '0 : ram_q;
  assign COUNT        = cnt;
  assign ALMOST_FULL  = (cnt >= AF_LVL);
  assign ALMOST_EMPTY = (cnt <= AE_LVL);

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: vector table,
// directed corner sequences and random traffic against a queue model.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       WR_EN = 1'b0;
  logic       RD_EN = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic [7:0] DOUT;
  logic       FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
  logic [4:0] COUNT;
  logic       OVERFLOW, UNDERFLOW;

  sync_fifo_param #(
    .DATA_W    (8),
    .DEPTH     (DEPTH),
    .AF_MARGIN (2),
    .AE_MARGIN (2)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .DIN          (DIN),
    .WR_EN        (WR_EN),
    .RD_EN        (RD_EN),
    .CLR_ERR      (CLR_ERR),
    .DOUT         (DOUT),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .COUNT        (COUNT),
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of stored words plus the visible flags.
  logic [7:0] mq[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  task automatic model_edge(input logic rst, wr, rd, clr,
                            input logic [7:0] din);
    bit f, e;
    if (rst) begin
      mq.delete();
      m_dout = 8'h00;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      f = (mq.size() == DEPTH);
      e = (mq.size() == 0);
      if (wr && f) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (rd && e) m_unf = 1'b1;
      else if (clr) m_unf = 1'b0;
      if (rd && !e) m_dout = mq.pop_front();
      if (wr && !f) mq.push_back(din);
    end
  endtask

  task automatic step(input logic rst, wr, rd, clr,
                      input logic [7:0] din);
    RST = rst;
    WR_EN = wr;
    RD_EN = rd;
    CLR_ERR = clr;
    DIN = din;
    @(posedge CLK);
    model_edge(rst, wr, rd, clr, din);
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(COUNT), 32'(n));
    chk({tag, ".empty"}, 32'(EMPTY), 32'(n == 0));
    chk({tag, ".full"}, 32'(FULL), 32'(n == DEPTH));
    chk({tag, ".af"}, 32'(ALMOST_FULL), 32'(n >= DEPTH - 2));
    chk({tag, ".ae"}, 32'(ALMOST_EMPTY), 32'(n <= 2));
    chk({tag, ".dout"}, 32'(DOUT), 32'(m_dout));
    chk({tag, ".ovf"}, 32'(OVERFLOW), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(UNDERFLOW), 32'(m_unf));
  endtask

  // ctrl = {rst, wr, rd, clr}; flg = {empty, full, ovf, unf}
  typedef struct {
    logic [3:0] ctrl;
    logic [7:0] din;
    int         cnt;
    logic [3:0] flg;
    logic [7:0] dout;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ctrl,
                              input logic [7:0] din,
                              input int cnt,
                              input logic [3:0] flg,
                              input logic [7:0] dout);
    vec_t v;
    v.ctrl = ctrl;
    v.din = din;
    v.cnt = cnt;
    v.flg = flg;
    v.dout = dout;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
`ifndef SYNC_FIFO_FWFT_EN
    tbl[0]  = mk(4'b1000, 8'h00, 0, 4'b1000, 8'h00);
    tbl[1]  = mk(4'b0010, 8'h00, 0, 4'b1001, 8'h00);
    tbl[2]  = mk(4'b0001, 8'h00, 0, 4'b1000, 8'h00);
    tbl[3]  = mk(4'b0100, 8'h11, 1, 4'b0000, 8'h00);
    tbl[4]  = mk(4'b0100, 8'h22, 2, 4'b0000, 8'h00);
    tbl[5]  = mk(4'b0010, 8'h00, 1, 4'b0000, 8'h11);
    tbl[6]  = mk(4'b0110, 8'h33, 1, 4'b0000, 8'h22);
    tbl[7]  = mk(4'b0010, 8'h00, 0, 4'b1000, 8'h33);
    tbl[8]  = mk(4'b0110, 8'h44, 1, 4'b0001, 8'h33);
    tbl[9]  = mk(4'b0011, 8'h00, 0, 4'b1000, 8'h44);
    tbl[10] = mk(4'b0011, 8'h00, 0, 4'b1001, 8'h44);
    tbl[11] = mk(4'b1111, 8'h99, 0, 4'b1000, 8'h00);

    foreach (tbl[i]) begin
      step(tbl[i].ctrl[3], tbl[i].ctrl[2], tbl[i].ctrl[1],
           tbl[i].ctrl[0], tbl[i].din);
      chk($sformatf("tbl%0d.count", i), 32'(COUNT), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.flags", i),
          32'({EMPTY, FULL, OVERFLOW, UNDERFLOW}), 32'(tbl[i].flg));
      chk($sformatf("tbl%0d.dout", i), 32'(DOUT), 32'(tbl[i].dout));
    end

    // Fill 0x01..0x10
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'(i + 1));
      chk($sformatf("fill%0d.count", i), 32'(COUNT), 32'(i + 1));
      chk($sformatf("fill%0d.af", i), 32'(ALMOST_FULL),
          32'(i + 1 >= 14));
      chk($sformatf("fill%0d.full", i), 32'(FULL), 32'(i == 15));
    end

    // Drain, expecting in-order data with 1-cycle latency
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("drain%0d.dout", i), 32'(DOUT), 32'(i + 1));
      chk($sformatf("drain%0d.ae", i), 32'(ALMOST_EMPTY),
          32'(15 - i <= 2));
    end
    chk("drain.empty", 32'(EMPTY), 32'(1));
    chk("drain.count", 32'(COUNT), 32'(0));

    // Overflow: refill, then write+read while full
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'(i + 1));
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
    chk("ovf.count", 32'(COUNT), 32'(15));
    chk("ovf.flag", 32'(OVERFLOW), 32'(1));
    chk("ovf.dout", 32'(DOUT), 32'(1));
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("ovfrd%0d.dout", i), 32'(DOUT), 32'(i + 2));
    end
    chk("ovf.empty", 32'(EMPTY), 32'(1));
    chk("ovf.held", 32'(OVERFLOW), 32'(1));
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("ovf.clr", 32'(OVERFLOW), 32'(0));

    // Wrap: keep three entries in flight across several pointer wraps
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'(k + 3));
      chk($sformatf("wrap%0d.dout", k), 32'(DOUT), 32'(k));
      chk($sformatf("wrap%0d.count", k), 32'(COUNT), 32'(3));
      chk($sformatf("wrap%0d.fe", k), 32'({FULL, EMPTY}), 32'(0));
    end

    // Reset in the middle of traffic
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h70);
    chk("mid.count7", 32'(COUNT), 32'(7));
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
    chk("mid.count", 32'(COUNT), 32'(0));
    chk("mid.empty", 32'(EMPTY), 32'(1));
    chk("mid.dout", 32'(DOUT), 32'(0));
    check_model("mid");

    // Random traffic against the queue model, biased in phases
    for (int c = 0; c < 600; c++) begin
      int wb;
      logic r, w, rd, cl;
      wb = ((c / 60) % 2 == 0) ? 75 : 25;
      r  = ($urandom_range(0, 99) < 2);
      w  = ($urandom_range(0, 99) < wb);
      rd = ($urandom_range(0, 99) < 100 - wb);
      cl = ($urandom_range(0, 99) < 6);
      step(r, w, rd, cl, 8'($urandom));
      check_model($sformatf("rnd%0d", c));
    end
`else
    // First-word-fall-through behaviour
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw.rst.empty", 32'(EMPTY), 32'(1));
    chk("fw.rst.count", 32'(COUNT), 32'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
    chk("fw.w.empty", 32'(EMPTY), 32'(1));
    chk("fw.w.count", 32'(COUNT), 32'(1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw.empty", 32'(EMPTY), 32'(0));
    chk("fw.dout", 32'(DOUT), 32'(8'h5A));
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
    chk("fw.count4", 32'(COUNT), 32'(4));
    chk("fw.head", 32'(DOUT), 32'(8'h5A));
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp;
      exp = (i == 0) ? 8'h5A : 8'(i);
      chk($sformatf("fw.pop%0d.dout", i), 32'(DOUT), 32'(exp));
      chk($sformatf("fw.pop%0d.empty", i), 32'(EMPTY), 32'(0));
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    end
    chk("fw.end.empty", 32'(EMPTY), 32'(1));
    chk("fw.end.count", 32'(COUNT), 32'(0));
    chk("fw.end.unf", 32'(UNDERFLOW), 32'(0));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
